// File: rtl/ringosc_entropy_sampler_pkg.sv
// Shared types for the ring-oscillator entropy path.
package ringosc_entropy_sampler_pkg;

  typedef enum logic {
    VN_FIRST  = 1'b0,
    VN_SECOND = 1'b1
  } vn_state_e;

endpackage

// File: rtl/von_neumann_debias.sv
// Von Neumann debiaser: emits the first bit of every unequal pair of strobed input bits.
module von_neumann_debias
  import ringosc_entropy_sampler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic in_bit,
  input  logic in_strobe,
  output logic out_bit,
  output logic out_strobe
);

  vn_state_e state_q;
  vn_state_e state_d;
  logic      b0_q;
  logic      b0_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= VN_FIRST;
      b0_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      b0_q    <= b0_d;
    end
  end

  // The strobe leaves combinationally so a finished pair reaches the packer on the same edge.
  always_comb begin
    state_d    = state_q;
    b0_d       = b0_q;
    out_bit    = b0_q;
    out_strobe = 1'b0;
    if (clear) begin
      state_d = VN_FIRST;
      b0_d    = 1'b0;
    end else if (in_strobe) begin
      case (state_q)
        VN_FIRST: begin
          b0_d    = in_bit;
          state_d = VN_SECOND;
        end
        VN_SECOND: begin
          out_strobe = (in_bit != b0_q);
          state_d    = VN_FIRST;
        end
        default: state_d = VN_FIRST;
      endcase
    end
  end

endmodule

// File: rtl/ringosc_entropy_sampler.sv
// Synchronizes a ring oscillator, XOR-decimates it, debiases the raw bits and
// packs them into words on a valid/ready stream.
module ringosc_entropy_sampler
  import ringosc_entropy_sampler_pkg::*;
#(
  parameter int unsigned SAMPLE_CYCLES = 16,
  parameter int unsigned WORD_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  osc_in,
  input  logic                  enable,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  localparam int unsigned CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int unsigned BIT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_WIDTH - 1);

  (* keep *) logic sync_s1;
  (* keep *) logic sync_s2;

  logic [CNT_W-1:0]      cnt_q;
  logic                  acc_q;
  logic                  raw_strobe_c;
  logic                  raw_bit_c;
  logic                  deb_bit;
  logic                  deb_strobe;
  logic [WORD_WIDTH-1:0] shreg_q;
  logic [BIT_W-1:0]      bitcnt_q;
  logic                  held_q;
  logic                  xfer_c;
  logic                  load_c;
  logic                  drop_c;
  logic                  accept_c;
  logic                  word_done_c;

  // osc_in fans out only into this two-flop synchronizer.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_s1 <= 1'b0;
      sync_s2 <= 1'b0;
    end else begin
      sync_s1 <= osc_in;
      sync_s2 <= sync_s1;
    end
  end

  assign raw_strobe_c = enable && (cnt_q == CNT_LAST);
  assign raw_bit_c    = acc_q ^ sync_s2;

  // XOR decimation window; disabling restarts the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= 1'b0;
    end else if (!enable || raw_strobe_c) begin
      cnt_q <= '0;
      acc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
      acc_q <= acc_q ^ sync_s2;
    end
  end

  von_neumann_debias u_debias (
    .clk       (clk),
    .rst       (rst),
    .clear     (!enable),
    .in_bit    (raw_bit_c),
    .in_strobe (raw_strobe_c),
    .out_bit   (deb_bit),
    .out_strobe(deb_strobe)
  );

  // A completed word waits in shreg (held_q) until the output register is free.
  assign xfer_c      = out_valid && out_ready;
  assign load_c      = held_q && (!out_valid || xfer_c);
  assign drop_c      = deb_strobe && held_q && !load_c;
  assign accept_c    = deb_strobe && !drop_c;
  assign word_done_c = accept_c && (bitcnt_q == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      held_q    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (accept_c) begin
        shreg_q  <= WORD_WIDTH'({shreg_q, deb_bit});
        bitcnt_q <= word_done_c ? '0 : bitcnt_q + BIT_W'(1);
      end
      held_q <= word_done_c || (held_q && !load_c);
      if (load_c) begin
        out_data  <= shreg_q;
        out_valid <= 1'b1;
      end else if (xfer_c) begin
        out_valid <= 1'b0;
      end
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ringosc_entropy_sampler.sv
// Directed table tests plus randomized lockstep checking against a behavioural model.
module tb_ringosc_entropy_sampler;

  localparam int SC_A = 1;
  localparam int W_A  = 8;
  localparam int SC_B = 3;
  localparam int W_B  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, osc, enable, rdy, clr;
  logic [W_A-1:0] data_a;
  logic           valid_a, ovf_a;
  logic [W_B-1:0] data_b;
  logic           valid_b, ovf_b;

  ringosc_entropy_sampler #(.SAMPLE_CYCLES(SC_A), .WORD_WIDTH(W_A)) dut_a (
    .clk(clk), .rst(rst), .osc_in(osc), .enable(enable),
    .out_data(data_a), .out_valid(valid_a), .out_ready(rdy),
    .overflow(ovf_a), .overflow_clr(clr)
  );

  ringosc_entropy_sampler #(.SAMPLE_CYCLES(SC_B), .WORD_WIDTH(W_B)) dut_b (
    .clk(clk), .rst(rst), .osc_in(osc), .enable(enable),
    .out_data(data_b), .out_valid(valid_b), .out_ready(rdy),
    .overflow(ovf_b), .overflow_clr(clr)
  );

  typedef struct packed {
    int          cnt;
    int          nb;
    logic [31:0] word;
    logic [31:0] od;
    logic        s1, s2, acc, vn_have, vn_b0, pending, ov, ovf;
  } mdl_t;

  typedef struct {
    logic [3:0] pat;
    int         len;
    logic [7:0] word;
    int         lat;
  } vec_t;

  mdl_t ma, mb;
  int   n_vec = 0;
  int   n_err = 0;

  // One clock edge of the specified behaviour, from the previous state and the sampled inputs.
  function automatic mdl_t mstep(input mdl_t m, input int sc, input int wd,
                                 input logic r, input logic o, input logic en,
                                 input logic rd, input logic cl);
    mdl_t n;
    logic raw_str, raw, deb_str, deb, xfer, load, drop;
    n = m;
    if (r) begin
      n = '0;
      return n;
    end
    raw_str = en && (m.cnt == sc - 1);
    raw     = m.acc ^ m.s2;
    deb_str = 1'b0;
    deb     = 1'b0;
    if (!en) begin
      n.cnt = 0; n.acc = 1'b0; n.vn_have = 1'b0;
    end else if (raw_str) begin
      n.cnt = 0; n.acc = 1'b0;
      if (m.vn_have) begin
        n.vn_have = 1'b0;
        if (raw != m.vn_b0) begin deb_str = 1'b1; deb = m.vn_b0; end
      end else begin
        n.vn_have = 1'b1; n.vn_b0 = raw;
      end
    end else begin
      n.cnt = m.cnt + 1; n.acc = m.acc ^ m.s2;
    end
    xfer = m.ov && rd;
    load = m.pending && (!m.ov || xfer);
    if (load) begin
      n.od = m.word; n.ov = 1'b1; n.pending = 1'b0;
    end else if (xfer) begin
      n.ov = 1'b0;
    end
    drop = deb_str && m.pending && !load;
    if (deb_str && !drop) begin
      n.word = ((m.word << 1) | 32'(deb)) & ((32'd1 << wd) - 32'd1);
      n.nb   = m.nb + 1;
      if (n.nb == wd) begin n.nb = 0; n.pending = 1'b1; end
    end
    if (drop) n.ovf = 1'b1;
    else if (cl) n.ovf = 1'b0;
    n.s2 = m.s1;
    n.s1 = o;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    ma = mstep(ma, SC_A, W_A, rst, osc, enable, rdy, clr);
    mb = mstep(mb, SC_B, W_B, rst, osc, enable, rdy, clr);
    #1;
    chk("model_a_valid", 32'(valid_a), 32'(ma.ov));
    chk("model_a_data",  32'(data_a),  ma.od);
    chk("model_a_ovf",   32'(ovf_a),   32'(ma.ovf));
    chk("model_b_valid", 32'(valid_b), 32'(mb.ov));
    chk("model_b_data",  32'(data_b),  mb.od);
    chk("model_b_ovf",   32'(ovf_b),   32'(mb.ovf));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Drives a repeating pattern from just after reset until out_valid; lat counts edges.
  task automatic run_pat(input logic [3:0] pat, input int len, input int bound, output int lat);
    lat = -1;
    for (int j = 0; j < bound; j++) begin
      osc = pat[j % len];
      step();
      if (valid_a) begin
        lat = j + 1;
        return;
      end
    end
  endtask

  initial begin
    vec_t tbl[5];
    int   lat, seen, bad, j;

    tbl[0] = '{pat: 4'b0001, len: 2, word: 8'hFF, lat: 19};
    tbl[1] = '{pat: 4'b0010, len: 2, word: 8'h00, lat: 19};
    tbl[2] = '{pat: 4'b1001, len: 4, word: 8'hAA, lat: 19};
    tbl[3] = '{pat: 4'b0110, len: 4, word: 8'h55, lat: 19};
    tbl[4] = '{pat: 4'b0111, len: 4, word: 8'hFF, lat: 35};

    rst = 1'b1; osc = 1'b0; enable = 1'b1; rdy = 1'b1; clr = 1'b0;
    ma = '0; mb = '0;
    do_reset();
    chk("reset_valid", 32'(valid_a), 32'd0);
    chk("reset_data",  32'(data_a),  32'd0);
    chk("reset_ovf",   32'(ovf_a),   32'd0);

    // Constant input never yields a word.
    do_reset();
    seen = 0;
    osc = 1'b0;
    for (int i = 0; i < 200; i++) begin step(); if (valid_a) seen++; end
    osc = 1'b1;
    for (int i = 0; i < 200; i++) begin step(); if (valid_a) seen++; end
    chk("const_no_valid", 32'(seen), 32'd0);
    chk("const_no_ovf", 32'(ovf_a), 32'd0);

    for (int t = 0; t < 5; t++) begin
      do_reset();
      rdy = 1'b1;
      run_pat(tbl[t].pat, tbl[t].len, 100, lat);
      chk($sformatf("tbl%0d_latency", t), 32'(lat), 32'(tbl[t].lat));
      chk($sformatf("tbl%0d_word", t), 32'(data_a), 32'(tbl[t].word));
    end

    // Backpressure: hold first word, hold second in shreg, then overflow.
    do_reset();
    rdy = 1'b0;
    for (j = 0; j < 100 && !valid_a; j++) begin osc = (j % 2 == 0); step(); end
    chk("bp_first_latency", 32'(j), 32'd19);
    chk("bp_first_word", 32'(data_a), 32'hFF);
    bad = 0;
    for (; j < 200 && !ovf_a; j++) begin
      osc = (j % 2 == 0);
      step();
      if (!valid_a || data_a !== 8'hFF) bad++;
    end
    chk("bp_ovf_set", 32'(ovf_a), 32'd1);
    chk("bp_ovf_edge", 32'(j), 32'd36);
    chk("bp_data_stable", 32'(bad), 32'd0);
    rdy = 1'b1;
    osc = (j % 2 == 0); step(); j++;
    chk("bp_second_valid", 32'(valid_a), 32'd1);
    chk("bp_second_word", 32'(data_a), 32'hFF);
    osc = (j % 2 == 0); step(); j++;
    chk("bp_drained", 32'(valid_a), 32'd0);
    chk("bp_ovf_sticky", 32'(ovf_a), 32'd1);
    clr = 1'b1;
    osc = (j % 2 == 0); step(); j++;
    clr = 1'b0;
    chk("bp_ovf_cleared", 32'(ovf_a), 32'd0);

    // Reset mid-word with a word sitting in the output register.
    do_reset();
    rdy = 1'b0;
    for (j = 0; j < 28; j++) begin osc = (j % 2 == 0); step(); end
    chk("midrst_pre_valid", 32'(valid_a), 32'd1);
    do_reset();
    chk("midrst_valid", 32'(valid_a), 32'd0);
    chk("midrst_data", 32'(data_a), 32'd0);
    rdy = 1'b1;
    run_pat(4'b1001, 4, 100, lat);
    chk("midrst_latency", 32'(lat), 32'd19);
    chk("midrst_word", 32'(data_a), 32'hAA);

    // Enable low mid-pair: pending b0 dropped, three leading ones kept.
    do_reset();
    rdy = 1'b1;
    for (j = 0; j < 9; j++) begin osc = (j % 2 == 0); step(); end
    enable = 1'b0;
    for (; j < 19; j++) begin osc = 1'b0; step(); end
    enable = 1'b1;
    for (; j < 200 && !valid_a; j++) begin osc = ((j - 19) % 2 == 1); step(); end
    chk("en_latency", 32'(j), 32'd32);
    chk("en_word", 32'(data_a), 32'hE0);

    // Randomized traffic checked in lockstep against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      osc    = 1'($urandom);
      enable = ($urandom % 16) != 0;
      rdy    = (i < 2000) ? (($urandom % 4) != 0) : (($urandom % 8) == 0);
      clr    = ($urandom % 64) == 0;
      rst    = ($urandom % 700) == 0;
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
